// File: rtl/uart_transmitter_core_if.sv
// Byte-in / serial-out handshake bundle for the UART transmitter core.
interface uart_transmitter_core_if;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output baud_tick, tx_data, tx_start,
        input  tx_serial, tx_busy, tx_done
    );

    modport slave (
        input  baud_tick, tx_data, tx_start,
        output tx_serial, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_transmitter_core.sv
// UART transmitter: 1 start, 8 data (LSB first), optional parity, 1 or 2
// stop bits. Bit boundaries come from rising edges of an external baud level.
module uart_transmitter_core #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_transmitter_core_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    // Index of the final stop bit; anything other than 2 behaves as 1.
    localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] idx_q, idx_d;
    logic       baud_q;
    logic       serial_q, serial_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick;

    // Rising edge of the baud level: pulses and long levels both count once.
    assign tick = bus.baud_tick & ~baud_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state, bit counter and latched byte; ARM waits for a boundary so
    // the start bit always spans a full baud period.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    shreg_d = bus.tx_data;
                    idx_d   = 3'd0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (tick) state_d = START;
            end
            START: begin
                if (tick) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    idx_d   = 3'd0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (idx_q == STOP_LAST) begin
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the upcoming state so the registered output
    // changes exactly on state entry / tick cycles.
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shreg_d[idx_d];
            PARITY:  serial_d = (^shreg_d) ^ (PARITY_ODD != 0);
            default: serial_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers; outputs are glitch-free flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q  <= 8'h00;
            idx_q    <= 3'd0;
            baud_q   <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            baud_q   <= bus.baud_tick;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.tx_serial = serial_q;
    assign bus.tx_busy   = busy_q;
    assign bus.tx_done   = done_q;

endmodule

// File: tb/tb_uart_transmitter_core.sv
// Bench for uart_transmitter_core: three parameter sets share one stimulus
// stream; a frame-queue model predicts line/busy/done every cycle.
module tb_uart_transmitter_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bt = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    int         mode = 0;

    always #5 clk = ~clk;

    uart_transmitter_core_if bus0();
    uart_transmitter_core_if bus1();
    uart_transmitter_core_if bus2();

    assign bus0.baud_tick = bt;  assign bus0.tx_data = data;  assign bus0.tx_start = start;
    assign bus1.baud_tick = bt;  assign bus1.tx_data = data;  assign bus1.tx_start = start;
    assign bus2.baud_tick = bt;  assign bus2.tx_data = data;  assign bus2.tx_start = start;

    logic [2:0] ser, bsy, dn;
    assign ser = {bus2.tx_serial, bus1.tx_serial, bus0.tx_serial};
    assign bsy = {bus2.tx_busy,   bus1.tx_busy,   bus0.tx_busy};
    assign dn  = {bus2.tx_done,   bus1.tx_done,   bus0.tx_done};

    uart_transmitter_core dut0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_transmitter_core #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_transmitter_core #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int checks = 0;
    int errors = 0;
    int done_cnt[3] = '{0, 0, 0};

    // Model: each configuration holds the list of line levels still to send
    // (leading 1 = wait for first boundary); every boundary consumes one.
    bit mq[3][16];
    int mlen[3] = '{0, 0, 0};
    int mpos[3] = '{0, 0, 0};
    bit mdone[3] = '{0, 0, 0};
    bit mprev = 1'b0;
    bit mtick;

    function automatic bit cfg_pe(input int m);  return (m != 0); endfunction
    function automatic bit cfg_odd(input int m); return (m == 2); endfunction
    function automatic int cfg_sb(input int m);  return (m == 1) ? 2 : 1; endfunction

    function automatic void build(input int m, input logic [7:0] d);
        int n;
        n = 0;
        mq[m][n++] = 1'b1;
        mq[m][n++] = 1'b0;
        for (int i = 0; i < 8; i++) mq[m][n++] = d[i];
        if (cfg_pe(m)) mq[m][n++] = (^d) ^ cfg_odd(m);
        for (int s = 0; s < cfg_sb(m); s++) mq[m][n++] = 1'b1;
        mlen[m] = n;
        mpos[m] = 0;
    endfunction

    function automatic bit model_busy();
        return (mpos[0] < mlen[0]) || (mpos[1] < mlen[1]) || (mpos[2] < mlen[2]);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            for (int m = 0; m < 3; m++) begin
                mlen[m] = 0; mpos[m] = 0; mdone[m] = 1'b0;
            end
            mprev = 1'b0;
        end else begin
            mtick = bt & ~mprev;
            for (int m = 0; m < 3; m++) begin
                mdone[m] = 1'b0;
                if (mpos[m] >= mlen[m]) begin
                    if (start) build(m, data);
                end else if (mtick) begin
                    mpos[m]++;
                    if (mpos[m] >= mlen[m]) mdone[m] = 1'b1;
                end
            end
            mprev = bt;
        end
    end

    // Per-cycle comparison of all three DUTs against the model.
    initial forever begin
        @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            logic es, eb;
            es = (mpos[m] < mlen[m]) ? mq[m][mpos[m]] : 1'b1;
            eb = (mpos[m] < mlen[m]);
            checks++;
            if (ser[m] !== es || bsy[m] !== eb || dn[m] !== mdone[m]) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0t serial/busy/done=%b%b%b expected %b%b%b",
                         m, $time, ser[m], bsy[m], dn[m], es, eb, mdone[m]);
            end
            if (dn[m] === 1'b1) done_cnt[m]++;
        end
    end

    // Baud source: 0 = 200 ns square wave, 1 = 1-clk pulse every 16, 2 = random levels.
    int bcnt = 0;
    initial forever begin
        @(negedge clk);
        bcnt++;
        case (mode)
            0:       bt = ((bcnt % 20) < 10);
            1:       bt = ((bcnt % 16) == 0);
            default: if ($urandom_range(0, 5) == 0) bt = ~bt;
        endcase
    end

    // Pins the model's frame for config m against a hand-written level list.
    task automatic pin(input int m, input logic [15:0] exp, input int len, input string nm);
        logic [15:0] got;
        got = '0;
        for (int i = 0; i < mlen[m]; i++) got = {got[14:0], mq[m][i]};
        checks++;
        if (mlen[m] != len || got != exp) begin
            errors++;
            $display("FAIL pin_%s got %h len %0d expected %h len %0d", nm, got, mlen[m], exp, len);
        end
    endtask

    task automatic send(input logic [7:0] d);
        data = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while (model_busy() && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout_%s waited %0d cycles limit %0d", nm, n, budget);
        end
        @(negedge clk);
    endtask

    task automatic check_done(input int exp, input string nm);
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (done_cnt[m] != exp) begin
                errors++;
                $display("FAIL done_%s dut%0d count %0d expected %0d", nm, m, done_cnt[m], exp);
            end
        end
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        checks++;
        if (ser !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000) begin
            errors++;
            $display("FAIL reset serial=%b busy=%b done=%b expected 111 000 000", ser, bsy, dn);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 0x41 with a 200 ns square baud: 0,1,0,0,0,0,0,1,0,1
        send(8'h41);
        pin(0, 16'b10100000101, 11, "41");
        wait_idle(400, "41");
        check_done(1, "41");

        repeat (100) @(negedge clk);
        send(8'h42);
        pin(0, 16'b10010000101, 11, "42");
        wait_idle(400, "42");
        check_done(2, "42");

        // data changes right after acceptance; extra requests mid-frame ignored
        data = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0; data = 8'hAA;
        pin(0, 16'b10101010101, 11, "55");
        for (int k = 0; k < 3; k++) begin
            repeat (30) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_idle(400, "55");
        check_done(3, "55");

        // parity: 0x07 has three ones -> even parity 1, odd parity 0
        send(8'h07);
        pin(1, 16'b1011100000111, 13, "07even2stop");
        pin(2, 16'b101110000001, 12, "07odd");
        wait_idle(400, "07");
        check_done(4, "07");

        // asynchronous reset in the middle of the data bits
        send(8'h41);
        repeat (60) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (ser !== 3'b111 || bsy !== 3'b000 || dn !== 3'b000) begin
            errors++;
            $display("FAIL async_rst serial=%b busy=%b done=%b expected 111 000 000", ser, bsy, dn);
        end
        repeat (4) @(negedge clk);
        check_done(4, "abort");
        rst = 1'b1;
        send(8'h41);
        pin(0, 16'b10100000101, 11, "41_after_rst");
        wait_idle(400, "41_after_rst");
        check_done(5, "after_rst");

        // 16-clk baud pulses, request held high: back-to-back frames
        mode = 1;
        base = done_cnt[0];
        start = 1'b1;
        for (int c = 0; c < 700; c++) begin
            data = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle(600, "b2b");
        checks++;
        if (done_cnt[0] - base < 3) begin
            errors++;
            $display("FAIL b2b frames %0d expected at least 3", done_cnt[0] - base);
        end

        // random frames, random baud levels, occasional reset
        mode = 2;
        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            data = 8'($urandom);
            start = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            start = 1'b0;
            data = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(5, 80)) @(negedge clk);
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(5, 50)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle(3000, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter_core.md
UART_TRANSMITTER_CORE -- requirements
Module: uart_transmitter

Interface
REQ-001 The parameter PARITY_EN SHALL default to 0 and, when 1, SHALL insert one parity bit after the data bits.
REQ-002 The parameter PARITY_ODD SHALL default to 0 and SHALL select even parity (0) or odd parity (1).
REQ-003 The parameter STOP_BITS SHALL default to 1, SHALL accept only 1 or 2, and SHALL set the number of stop bits.
REQ-004 Port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-006 Port baud_tick SHALL be an input, 1 bit wide: baud timing level; each 0->1 transition marks one bit-period boundary.
REQ-007 Port tx_data SHALL be an input, 8 bits wide, carrying the byte to send.
REQ-008 Port tx_start SHALL be an input, 1 bit wide, and SHALL request transmission when high.
REQ-009 Port tx_serial SHALL be an output, 1 bit wide: serial line; idle high.
REQ-010 Port tx_busy SHALL be an output, 1 bit wide, high while a frame is in progress.
REQ-011 Port tx_done SHALL be an output, 1 bit wide, pulsing high for one clk cycle at frame completion.

Function
REQ-012 The DUT SHALL register baud_tick, and a bit boundary ("tick") SHALL be the clk cycle where the current sample is 1 and the previous sample is 0; this makes single-cycle pulses and multi-cycle levels equivalent.
REQ-013 The state machine SHALL have the states IDLE, ARM, START, DATA, PARITY and STOP.
REQ-014 In IDLE: tx_serial=1, tx_busy=0; tx_start=1 at a clk edge SHALL latch tx_data into a shift register and move to ARM.
REQ-015 In ARM: tx_serial=1, tx_busy=1; on the next tick the DUT SHALL move to START, so the start bit is always one full baud period.
REQ-016 In START: tx_serial=0; on a tick the DUT SHALL move to DATA with bit index 0.
REQ-017 In DATA: tx_serial SHALL be data bit[index], LSB first; on each tick the index increments, and after bit 7 the DUT SHALL move to PARITY if PARITY_EN=1, else to STOP.
REQ-018 In PARITY: tx_serial SHALL be the XOR of the latched byte, XOR PARITY_ODD; on a tick the DUT SHALL move to STOP.
REQ-019 In STOP: tx_serial=1 for STOP_BITS ticks; on the final one the DUT SHALL return to IDLE, assert tx_done for exactly that one cycle, and drop tx_busy in the same cycle.
REQ-020 tx_busy SHALL be high from the cycle after acceptance through the end of the last stop bit.
REQ-021 tx_start SHALL be ignored while tx_busy=1; a request held high after a frame SHALL start a new frame in the first IDLE cycle.
REQ-022 A tx_start asserted in the tx_done cycle SHALL be accepted on the following clk edge, once in IDLE.
REQ-023 The latched byte SHALL be unaffected by changes on tx_data after acceptance.
REQ-024 The line SHALL change only on tick cycles or on state entry, with no glitches; tx_serial SHALL be driven from a register.
REQ-025 Frame length SHALL be 1 start + 8 data + PARITY_EN + STOP_BITS bit periods, plus 0..1 period of ARM latency.

Reset
REQ-026 rst=0 SHALL immediately force: state IDLE, tx_serial=1, tx_busy=0, tx_done=0, shift register=0, bit index=0, baud sample register=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no tx_done pulse.
REQ-028 After rst returns high, the DUT SHALL accept tx_start on the next edge.

Verification
REQ-029 With defaults, clk 10 ns and baud_tick a 200 ns-period square wave, sending 0x41 SHALL produce the line sequence 0,1,0,0,0,0,0,1,0,1, each bit 200 ns, followed by exactly one tx_done pulse and tx_busy falling.
REQ-030 A tx_start pulse of 0x42 issued 1000 ns after the first frame SHALL produce 0,0,1,0,0,0,0,1,0,1 and one tx_done pulse.
REQ-031 A tx_start pulse with tx_data=0x55, while tx_data changes to 0xAA on the next cycle, SHALL transmit 0x55; further tx_start pulses during the frame SHALL not change the frame or its length.
REQ-032 With PARITY_EN=1 and PARITY_ODD=0, sending 0x07 SHALL place parity bit 1 after the data bits; with STOP_BITS=2 the stop bits SHALL last 2 periods, and tx_done SHALL pulse at the end of the second.
REQ-033 Asserting rst=0 during the data bits SHALL force tx_serial=1 and tx_busy=0 asynchronously with no tx_done; a subsequent 0x41 frame SHALL then be correct.
REQ-034 With baud_tick driven as 1-clk pulses every 16 clocks and tx_start held high, the DUT SHALL transmit back-to-back frames, each bit lasting 16 clocks.
